// File: rtl/line_buf_pkg.sv
// Shared types and default geometry for the 3-line buffer sequencer.
package line_buf_pkg;

    localparam int unsigned DEF_SCREENWIDTH  = 1600;
    localparam int unsigned DEF_SCREENHEIGHT = 900;
    localparam int unsigned DEF_COLW         = $clog2(DEF_SCREENWIDTH);
    // Row counter must be able to hold SCREENHEIGHT itself (end-of-frame value).
    localparam int unsigned DEF_ROWW         = $clog2(DEF_SCREENHEIGHT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } lb_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// One-flop register of a timing strobe plus its rising-edge pulse.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic q;

    always_ff @(posedge clk) begin
        if (rst) q <= 1'b0;
        else     q <= d;
    end

    assign rise = d & ~q;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Sequencer for the 3-line pixel buffer feeding the 3x3 window filters.
// Optional line-length checker enabled by defining LINE_LEN_CHECK_EN.
module line_buffer_ctrl
    import line_buf_pkg::*;
#(
    parameter int unsigned SCREENWIDTH  = DEF_SCREENWIDTH,
    parameter int unsigned SCREENHEIGHT = DEF_SCREENHEIGHT,
    parameter int unsigned COLW         = $clog2(SCREENWIDTH),
    parameter int unsigned ROWW         = $clog2(SCREENHEIGHT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dv_i,
    input  logic            hs_i,
    input  logic            vs_i,
    output logic            buf_dv_o,
    output logic            line_end_o,
    output logic            win_valid_o,
    output logic [COLW-1:0] col_o,
    output logic [ROWW-1:0] row_o,
    output logic [1:0]      state_o,
    output logic            frame_done_o
`ifdef LINE_LEN_CHECK_EN
    ,
    output logic            err_len_o
`endif
);

    lb_state_t       state;
    logic [COLW-1:0] col;
    logic [ROWW-1:0] row;
    logic [ROWW-1:0] row_inc;
    logic            line_seen;
    logic            line_full;
    logic            hs_rise;
    logic            vs_rise;
    logic            active;
    logic            at_last;
    logic            win_hit;

    sync_edge_det u_hs_edge (.clk(clk), .rst(rst), .d(hs_i), .rise(hs_rise));
    sync_edge_det u_vs_edge (.clk(clk), .rst(rst), .d(vs_i), .rise(vs_rise));

    // col is the index of the next pixel; line_full marks the last column written.
    assign active   = (state == FILL) || (state == RUN);
    assign at_last  = (col == COLW'(SCREENWIDTH - 1));
    assign buf_dv_o = dv_i && active && !line_full;
    assign win_hit  = (state == RUN) && buf_dv_o && (col >= COLW'(2));
    assign row_inc  = row + ROWW'(1);
    assign state_o  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            line_seen    <= 1'b0;
            line_full    <= 1'b0;
            line_end_o   <= 1'b0;
            win_valid_o  <= 1'b0;
            col_o        <= '0;
            row_o        <= '0;
            frame_done_o <= 1'b0;
        end else begin
            line_end_o   <= hs_rise | vs_rise;
            frame_done_o <= 1'b0;
            win_valid_o  <= win_hit;
            if (win_hit) begin
                col_o <= col - COLW'(1);
                row_o <= row - ROWW'(1);
            end

            // A vs edge (re)starts a frame from any state and wins over line ends.
            if (vs_rise) begin
                state     <= FILL;
                row       <= '0;
                col       <= '0;
                line_seen <= 1'b0;
                line_full <= 1'b0;
            end else if (line_end_o) begin
                col       <= '0;
                line_seen <= 1'b0;
                line_full <= 1'b0;
                if (line_seen) begin
                    row <= row_inc;
                    if (state == FILL && row_inc == ROWW'(2)) begin
                        state <= RUN;
                    end else if (state == RUN && row_inc == ROWW'(SCREENHEIGHT)) begin
                        state        <= DONE;
                        frame_done_o <= 1'b1;
                    end
                end
            end else if (buf_dv_o) begin
                line_seen <= 1'b1;
                if (at_last) line_full <= 1'b1;
                else         col       <= col + COLW'(1);
            end
        end
    end

`ifdef LINE_LEN_CHECK_EN
    // Sticky: short line, or pixel dropped after the last column.
    always_ff @(posedge clk) begin
        if (rst || vs_rise) begin
            err_len_o <= 1'b0;
        end else if ((line_end_o && line_seen && !line_full) ||
                     (dv_i && active && line_full)) begin
            err_len_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl on a reduced 16x8 geometry.
module tb_line_buffer_ctrl;
    import line_buf_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned H  = 8;
    localparam int unsigned CW = $clog2(W);
    localparam int unsigned RW = $clog2(H + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          dv;
    logic          hs;
    logic          vs;
    logic          buf_dv_o;
    logic          line_end_o;
    logic          win_valid_o;
    logic [CW-1:0] col_o;
    logic [RW-1:0] row_o;
    logic [1:0]    state_o;
    logic          frame_done_o;
`ifdef LINE_LEN_CHECK_EN
    logic          err_len_o;
`endif

    line_buffer_ctrl #(.SCREENWIDTH(W), .SCREENHEIGHT(H)) dut (
        .clk(clk), .rst(rst), .dv_i(dv), .hs_i(hs), .vs_i(vs),
        .buf_dv_o(buf_dv_o), .line_end_o(line_end_o), .win_valid_o(win_valid_o),
        .col_o(col_o), .row_o(row_o), .state_o(state_o), .frame_done_o(frame_done_o)
`ifdef LINE_LEN_CHECK_EN
        , .err_len_o(err_len_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] col;
        logic [RW-1:0] row;
    } win_t;

    typedef struct {
        logic       dv;
        logic       hs;
        logic       vs;
        logic       exp_buf;
        logic       exp_le;
        logic [1:0] exp_st;
    } vec_t;

    win_t sb[$];
    vec_t tbl[11];
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   n_valid = 0;
    int   n_done  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every window the DUT flags must match the next expected one.
    always @(negedge clk) begin
        win_t e;
        if (frame_done_o) n_done++;
        if (win_valid_o) begin
            n_valid++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL win_unexpected: col_o=%0d row_o=%0d, required no window", col_o, row_o);
            end else begin
                e = sb.pop_front();
                check("win_col", int'(col_o), int'(e.col));
                check("win_row", int'(row_o), int'(e.row));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_px(input int n, input int r, input bit in_frame);
        for (int p = 0; p < n; p++) begin
            dv = 1'b1;
            #1;
            check("buf_dv", int'(buf_dv_o), int'(in_frame && p < int'(W)));
            if (in_frame && r >= 2 && r < int'(H) && p >= 2 && p < int'(W))
                sb.push_back('{col: CW'(p - 1), row: RW'(r - 1)});
            step();
        end
        dv = 1'b0;
    endtask

    task automatic hblank();
        hs = 1'b1; step(); step();
        hs = 1'b0; step(); step(); step();
    endtask

    task automatic vs_pulse();
        vs = 1'b1; step(); step();
        vs = 1'b0; step(); step(); step();
    endtask

    task automatic full_lines(input int first, input int last);
        for (int r = first; r <= last; r++) begin
            drive_px(W, r, 1'b1);
            hblank();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_buf_dv"}, int'(buf_dv_o), 0);
        check({tag, "_line_end"}, int'(line_end_o), 0);
        check({tag, "_win_valid"}, int'(win_valid_o), 0);
        check({tag, "_col"}, int'(col_o), 0);
        check({tag, "_row"}, int'(row_o), 0);
        check({tag, "_state"}, int'(state_o), int'(IDLE));
        check({tag, "_frame_done"}, int'(frame_done_o), 0);
`ifdef LINE_LEN_CHECK_EN
        check({tag, "_err_len"}, int'(err_len_o), 0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int d0;

        //            dv    hs    vs    buf   le    state
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, FILL};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FILL};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FILL};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, FILL};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, FILL};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, FILL};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FILL};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, FILL};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FILL};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, FILL};

        rst = 1'b1; dv = 1'b0; hs = 1'b0; vs = 1'b0;
        step(); step();
        check_all_zero("reset");
        rst = 1'b0;

        // Cycle-accurate timing vectors: buf_dv gate, line_end pulse, state.
        for (int i = 0; i < 11; i++) begin
            dv = tbl[i].dv; hs = tbl[i].hs; vs = tbl[i].vs;
            #1;
            check($sformatf("tbl%0d_buf_dv", i), int'(buf_dv_o), int'(tbl[i].exp_buf));
            step();
            check($sformatf("tbl%0d_line_end", i), int'(line_end_o), int'(tbl[i].exp_le));
            check($sformatf("tbl%0d_state", i), int'(state_o), int'(tbl[i].exp_st));
        end
        dv = 1'b0; hs = 1'b0; vs = 1'b0;

        // Full frame with one overlong line, then dv in DONE.
        rst = 1'b1; step(); rst = 1'b0;
        vs_pulse();
        check("frame_state_fill", int'(state_o), int'(FILL));
        full_lines(0, 1);
        check("frame_state_run", int'(state_o), int'(RUN));
        v0 = n_valid;
        full_lines(2, 2);
        check("valid_per_line", n_valid - v0, int'(W) - 2);
        v0 = n_valid;
        drive_px(W + 5, 3, 1'b1);
        hblank();
        check("valid_overlong", n_valid - v0, int'(W) - 2);
`ifdef LINE_LEN_CHECK_EN
        check("err_len_overlong", int'(err_len_o), 1);
`endif
        d0 = n_done;
        full_lines(4, int'(H) - 1);
        check("frame_done_once", n_done - d0, 1);
        check("frame_state_done", int'(state_o), int'(DONE));
        drive_px(4, int'(H), 1'b0);
        hblank();
        check("done_state_hold", int'(state_o), int'(DONE));

        // Abort mid-row 5 by a vs edge.
        vs_pulse();
        check("restart_state", int'(state_o), int'(FILL));
`ifdef LINE_LEN_CHECK_EN
        check("err_len_cleared", int'(err_len_o), 0);
`endif
        d0 = n_done;
        full_lines(0, 4);
        drive_px(6, 5, 1'b1);
        vs_pulse();
        check("abort_state", int'(state_o), int'(FILL));
        check("abort_no_done", n_done - d0, 0);
        full_lines(0, 1);
        check("abort_refill_run", int'(state_o), int'(RUN));
        full_lines(2, 2);

        // Reset in the middle of a RUN line.
        drive_px(5, 3, 1'b1);
        rst = 1'b1; dv = 1'b1;
        step();
        check_all_zero("midreset");
        rst = 1'b0;
        drive_px(4, 0, 1'b0);
        check("post_reset_idle", int'(state_o), int'(IDLE));
        vs_pulse();
        check("post_reset_fill", int'(state_o), int'(FILL));

        step(); step();
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
